// File: rtl/instr_fetch_unit_pkg.sv
// rtl/instr_fetch_unit_pkg.sv - shared opcode constants, NOP word and fetch state enum
// Also used by the main decoder.
package instr_fetch_unit_pkg;

  localparam logic [6:0]  OP_LOAD   = 7'b0000011;
  localparam logic [6:0]  OP_STORE  = 7'b0100011;
  localparam logic [6:0]  OP_RTYPE  = 7'b0110011;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [6:0]  OP_ITYPE  = 7'b0010011;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    VALID = 2'd2,
    ERR   = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - fetch unit bus: instruction memory and decode-side signals
// Ports:
//   imem_req/imem_addr      fetch request and address (fetch -> memory)
//   imem_ready/imem_rdata   memory response (memory -> fetch)
//   instr/op/instr_pc       current instruction, opcode, its address (fetch -> core)
//   instr_valid             instruction presented for decode/execute
//   instr_ack/stall         completion and hold from the core
//   pc_src/imm_ext          branch decision and sign-extended offset
//   misalign_err            sticky misaligned next-PC flag
// master = fetch unit, slave = memory + core.
interface instr_fetch_unit_if #(
  parameter int ADDR_WIDTH = 32
);

  logic                  imem_req;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic                  imem_ready;
  logic [31:0]           imem_rdata;
  logic [31:0]           instr;
  logic [6:0]            op;
  logic [ADDR_WIDTH-1:0] instr_pc;
  logic                  instr_valid;
  logic                  instr_ack;
  logic                  pc_src;
  logic [31:0]           imm_ext;
  logic                  stall;
  logic                  misalign_err;

  modport master (
    output imem_req, imem_addr,
    input  imem_ready, imem_rdata,
    output instr, op, instr_pc, instr_valid,
    input  instr_ack, pc_src, imm_ext, stall,
    output misalign_err
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ready, imem_rdata,
    input  instr, op, instr_pc, instr_valid,
    output instr_ack, pc_src, imm_ext, stall,
    input  misalign_err
  );

endinterface

// File: rtl/instr_fetch_unit_pc_next_calc.sv
// rtl/instr_fetch_unit_pc_next_calc.sv - combinational next-PC selection and alignment check
// Ports:
//   instr_pc    address of the instruction being completed
//   imm_ext     sign-extended branch offset
//   pc_src      1 = branch taken
//   next_pc     selected next PC, modulo 2^ADDR_WIDTH
//   misaligned  next_pc is not 4-byte aligned
module pc_next_calc #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] instr_pc,
  input  logic [31:0]           imm_ext,
  input  logic                  pc_src,
  output logic [ADDR_WIDTH-1:0] next_pc,
  output logic                  misaligned
);

  logic [ADDR_WIDTH-1:0] imm_addr;

  always_comb begin
    // Sign-extend (or truncate) the offset to the address width; sums wrap naturally.
    imm_addr   = ADDR_WIDTH'(signed'(imm_ext));
    next_pc    = pc_src ? (instr_pc + imm_addr) : (instr_pc + ADDR_WIDTH'(4));
    misaligned = (next_pc[1:0] != 2'b00);
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - sequential instruction fetch unit feeding the decode stage
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   bus    instr_fetch_unit_if.master (memory handshake + decode interface)
// Parameters:
//   ADDR_WIDTH  PC / memory address width
//   RESET_PC    PC loaded on reset
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input logic               clk,
  input logic               reset,
  instr_fetch_unit_if.master bus
);

  fetch_state_t          state;
  fetch_state_t          state_next;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] instr_pc;
  logic [31:0]           instr;
  logic                  misalign_err;

  logic [ADDR_WIDTH-1:0] pc_next;
  logic                  pc_next_misaligned;
  logic                  accept;

  pc_next_calc #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_pc_next_calc (
    .instr_pc   (instr_pc),
    .imm_ext    (bus.imm_ext),
    .pc_src     (bus.pc_src),
    .next_pc    (pc_next),
    .misaligned (pc_next_misaligned)
  );

  // Stall overrides ack; pc_src/imm_ext only matter when this is high.
  assign accept = bus.instr_ack & ~bus.stall;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = REQ;
      REQ:     if (bus.imem_ready) state_next = VALID;
      VALID:   if (accept) state_next = pc_next_misaligned ? ERR : REQ;
      ERR:     state_next = ERR;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      instr        <= NOP_INSTR;
      instr_pc     <= RESET_PC;
      misalign_err <= 1'b0;
    end else begin
      state <= state_next;
      if (state == REQ && bus.imem_ready) begin
        instr    <= bus.imem_rdata;
        instr_pc <= pc;
      end
      // A misaligned target parks the unit in ERR with pc left untouched.
      if (state == VALID && accept) begin
        if (pc_next_misaligned) begin
          misalign_err <= 1'b1;
        end else begin
          pc <= pc_next;
        end
      end
    end
  end

  // Outputs come only from registers, so no input reaches them combinationally.
  assign bus.imem_req     = (state == REQ);
  assign bus.imem_addr    = pc;
  assign bus.instr_valid  = (state == VALID);
  assign bus.instr        = instr;
  assign bus.op           = instr[6:0];
  assign bus.instr_pc     = instr_pc;
  assign bus.misalign_err = misalign_err;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed scoreboard bench for instr_fetch_unit
module tb_instr_fetch_unit;

  typedef struct {
    logic [31:0] word;
    logic [31:0] pc;
  } fetch_t;

  logic clk;
  logic reset_a;
  logic reset_b;
  int   total;
  int   bad;

  logic [31:0] exp_addr[$];
  fetch_t      exp_fetch[$];

  instr_fetch_unit_if #(.ADDR_WIDTH(32)) bus_a ();
  instr_fetch_unit_if #(.ADDR_WIDTH(32)) bus_b ();

  instr_fetch_unit #(
    .ADDR_WIDTH(32),
    .RESET_PC  (32'h0000_0000)
  ) dut_a (
    .clk  (clk),
    .reset(reset_a),
    .bus  (bus_a)
  );

  instr_fetch_unit #(
    .ADDR_WIDTH(32),
    .RESET_PC  (32'hFFFF_FFFC)
  ) dut_b (
    .clk  (clk),
    .reset(reset_b),
    .bus  (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return {addr[24:0], (addr[2] ? 7'b0010011 : 7'b0110011)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    bus_a.imem_rdata = mem_word(bus_a.imem_addr);
    bus_b.imem_rdata = mem_word(bus_b.imem_addr);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_req_a(input string tag);
    chk({tag, "_req"}, {31'd0, bus_a.imem_req}, 32'd1);
    chk({tag, "_nvalid"}, {31'd0, bus_a.instr_valid}, 32'd0);
    if (exp_addr.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s_addr obs=%h exp=none", tag, bus_a.imem_addr);
    end else begin
      chk({tag, "_addr"}, bus_a.imem_addr, exp_addr.pop_front());
    end
  endtask

  task automatic chk_valid_a(input string tag);
    fetch_t f;
    chk({tag, "_valid"}, {31'd0, bus_a.instr_valid}, 32'd1);
    chk({tag, "_nreq"}, {31'd0, bus_a.imem_req}, 32'd0);
    if (exp_fetch.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s_instr obs=%h exp=none", tag, bus_a.instr);
    end else begin
      f = exp_fetch.pop_front();
      chk({tag, "_instr"}, bus_a.instr, f.word);
      chk({tag, "_op"}, {25'd0, bus_a.op}, {25'd0, f.word[6:0]});
      chk({tag, "_pc"}, bus_a.instr_pc, f.pc);
    end
  endtask

  initial begin
    fetch_t f;
    total = 0;
    bad   = 0;
    reset_a = 1'b1;
    reset_b = 1'b1;
    bus_a.imem_ready = 1'b0; bus_a.imem_rdata = '0; bus_a.instr_ack = 1'b0;
    bus_a.pc_src = 1'b0; bus_a.imm_ext = '0; bus_a.stall = 1'b0;
    bus_b.imem_ready = 1'b0; bus_b.imem_rdata = '0; bus_b.instr_ack = 1'b0;
    bus_b.pc_src = 1'b0; bus_b.imm_ext = '0; bus_b.stall = 1'b0;

    repeat (3) step();

    // Reset state
    chk("rst_req",   {31'd0, bus_a.imem_req}, 32'd0);
    chk("rst_addr",  bus_a.imem_addr, 32'h0000_0000);
    chk("rst_instr", bus_a.instr, 32'h0000_0013);
    chk("rst_op",    {25'd0, bus_a.op}, 32'h0000_0013);
    chk("rst_ipc",   bus_a.instr_pc, 32'h0000_0000);
    chk("rst_valid", {31'd0, bus_a.instr_valid}, 32'd0);
    chk("rst_err",   {31'd0, bus_a.misalign_err}, 32'd0);
    chk("rst_b_addr", bus_b.imem_addr, 32'hFFFF_FFFC);
    chk("rst_b_ipc",  bus_b.instr_pc, 32'hFFFF_FFFC);

    // First fetch, zero-wait memory
    bus_a.imem_ready = 1'b1;
    reset_a = 1'b0;
    exp_addr.push_back(32'h0);
    step();
    chk_req_a("first");
    f.word = mem_word(32'h0); f.pc = 32'h0; exp_fetch.push_back(f);
    step();
    chk_valid_a("first");
    chk("first_op_rtype", {25'd0, bus_a.op}, {25'd0, 7'b0110011});

    // Sequential acks: 0x4, 0x8, 0xC, 0x10
    for (int k = 1; k <= 4; k++) begin
      bus_a.instr_ack = 1'b1;
      bus_a.pc_src = 1'b0;
      exp_addr.push_back(32'(4 * k));
      step();
      bus_a.instr_ack = 1'b0;
      chk_req_a($sformatf("seq%0d", k));
      f.word = mem_word(32'(4 * k)); f.pc = 32'(4 * k); exp_fetch.push_back(f);
      step();
      chk_valid_a($sformatf("seq%0d", k));
    end

    // Taken branch from 0x10 by -8, then 3 wait states
    bus_a.instr_ack = 1'b1;
    bus_a.pc_src = 1'b1;
    bus_a.imm_ext = 32'hFFFF_FFF8;
    exp_addr.push_back(32'h8);
    step();
    bus_a.instr_ack = 1'b0;
    bus_a.pc_src = 1'b0;
    bus_a.imem_ready = 1'b0;
    chk_req_a("branch");
    for (int w = 0; w < 3; w++) begin
      step();
      chk($sformatf("wait%0d_req", w), {31'd0, bus_a.imem_req}, 32'd1);
      chk($sformatf("wait%0d_addr", w), bus_a.imem_addr, 32'h8);
      chk($sformatf("wait%0d_valid", w), {31'd0, bus_a.instr_valid}, 32'd0);
    end
    bus_a.imem_ready = 1'b1;
    f.word = mem_word(32'h8); f.pc = 32'h8; exp_fetch.push_back(f);
    step();
    chk_valid_a("wait_done");

    // Stall beats ack; pc_src/imm_ext ignored meanwhile
    bus_a.stall = 1'b1;
    bus_a.instr_ack = 1'b1;
    bus_a.pc_src = 1'b1;
    bus_a.imm_ext = 32'h0000_0100;
    for (int s = 0; s < 2; s++) begin
      step();
      chk($sformatf("stall%0d_valid", s), {31'd0, bus_a.instr_valid}, 32'd1);
      chk($sformatf("stall%0d_req", s), {31'd0, bus_a.imem_req}, 32'd0);
      chk($sformatf("stall%0d_ipc", s), bus_a.instr_pc, 32'h8);
      chk($sformatf("stall%0d_instr", s), bus_a.instr, mem_word(32'h8));
      chk($sformatf("stall%0d_addr", s), bus_a.imem_addr, 32'h8);
    end
    bus_a.stall = 1'b0;
    bus_a.pc_src = 1'b0;
    exp_addr.push_back(32'hC);
    step();
    bus_a.instr_ack = 1'b0;
    chk_req_a("unstall");
    f.word = mem_word(32'hC); f.pc = 32'hC; exp_fetch.push_back(f);
    step();
    chk_valid_a("unstall");

    // Misaligned branch target: sticky error, no further requests
    bus_a.instr_ack = 1'b1;
    bus_a.pc_src = 1'b1;
    bus_a.imm_ext = 32'h0000_0002;
    step();
    bus_a.instr_ack = 1'b0;
    bus_a.pc_src = 1'b0;
    for (int e = 0; e < 3; e++) begin
      chk($sformatf("err%0d_flag", e), {31'd0, bus_a.misalign_err}, 32'd1);
      chk($sformatf("err%0d_req", e), {31'd0, bus_a.imem_req}, 32'd0);
      chk($sformatf("err%0d_valid", e), {31'd0, bus_a.instr_valid}, 32'd0);
      chk($sformatf("err%0d_addr", e), bus_a.imem_addr, 32'hC);
      step();
    end

    // Reset mid-REQ with a coincident ready: no capture
    reset_a = 1'b1;
    step();
    reset_a = 1'b0;
    bus_a.imem_ready = 1'b0;
    step();
    chk("midreq_req", {31'd0, bus_a.imem_req}, 32'd1);
    chk("midreq_err", {31'd0, bus_a.misalign_err}, 32'd0);
    reset_a = 1'b1;
    bus_a.imem_ready = 1'b1;
    step();
    chk("midrst_valid", {31'd0, bus_a.instr_valid}, 32'd0);
    chk("midrst_req",   {31'd0, bus_a.imem_req}, 32'd0);
    chk("midrst_instr", bus_a.instr, 32'h0000_0013);
    reset_a = 1'b0;
    bus_a.imem_ready = 1'b0;
    step();
    chk("postrst_valid", {31'd0, bus_a.instr_valid}, 32'd0);
    chk("postrst_instr", bus_a.instr, 32'h0000_0013);

    // Wrap from FFFF_FFFC to 0 on the second instance
    bus_b.imem_ready = 1'b1;
    reset_b = 1'b0;
    step();
    chk("wrap_req",  {31'd0, bus_b.imem_req}, 32'd1);
    chk("wrap_addr", bus_b.imem_addr, 32'hFFFF_FFFC);
    step();
    chk("wrap_valid", {31'd0, bus_b.instr_valid}, 32'd1);
    chk("wrap_ipc",   bus_b.instr_pc, 32'hFFFF_FFFC);
    chk("wrap_instr", bus_b.instr, mem_word(32'hFFFF_FFFC));
    bus_b.instr_ack = 1'b1;
    step();
    bus_b.instr_ack = 1'b0;
    chk("wrap_next_req",  {31'd0, bus_b.imem_req}, 32'd1);
    chk("wrap_next_addr", bus_b.imem_addr, 32'h0000_0000);
    chk("wrap_no_err",    {31'd0, bus_b.misalign_err}, 32'd0);

    chk("sb_addr_empty",  32'(exp_addr.size()), 32'd0);
    chk("sb_fetch_empty", 32'(exp_fetch.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
